// File: rtl/tdc_stop_line_ctrl.sv
// tdc_stop_line_ctrl: measurement sequencer for the CARRY4 stop delay line.
// Gates the line trigger, double-registers the tap vector, counts coarse clk
// cycles from arm to hit and popcount-encodes the sampled code into a fine
// value. The result is handed off over valid/ready. The line is then flushed
// back to all-zero before a new arm is accepted.
module tdc_stop_line_ctrl #(
    parameter int  NTAPS        = 180,
    parameter int  COARSE_W     = 16,
    parameter int  TIMEOUT      = 1000,
    parameter int  FLUSH_CYCLES = 4,
    localparam int FINE_W       = $clog2(NTAPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm_i,
    input  logic [NTAPS-1:0]    taps_i,
    output logic                dl_en_o,
    output logic                busy_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [COARSE_W-1:0] coarse_o,
    output logic [FINE_W-1:0]   fine_o,
    output logic                timeout_o
);

    localparam int LO_W    = NTAPS / 2;
    localparam int FLUSH_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [COARSE_W-1:0] COUNT_LAST = COARSE_W'(TIMEOUT - 1);
    localparam logic [FLUSH_W-1:0]  FLUSH_MIN  = FLUSH_W'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ENC1,
        ENC2,
        HOLD,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [NTAPS-1:0]    s1, s2, code_q;
    logic                hit;
    logic [COARSE_W-1:0] count_q, coarse_cap;
    logic                timeout_cap;
    logic [FINE_W-1:0]   pop_lo, pop_hi, sum_lo, sum_hi;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic                dl_en_q;

    assign hit     = |s2;
    assign dl_en_o = dl_en_q;

    // State register; the trigger gate is registered from the next state so it never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dl_en_q <= 1'b0;
        end else begin
            state   <= state_next;
            dl_en_q <= (state_next == ARMED);
        end
    end

    // Next-state decode plus the status outputs that follow directly from the state
    always_comb begin
        state_next = state;
        busy_o     = (state != IDLE);
        valid_o    = (state == HOLD);
        case (state)
            IDLE:    if (arm_i) state_next = ARMED;
            ARMED:   if (hit || (count_q == COUNT_LAST)) state_next = ENC1;
            ENC1:    state_next = ENC2;
            ENC2:    state_next = HOLD;
            HOLD:    if (ready_i) state_next = FLUSH;
            FLUSH:   if ((flush_cnt >= FLUSH_MIN) && !hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Half-width popcounts of the captured code; bubbles simply count as fewer ones
    always_comb begin
        sum_lo = '0;
        sum_hi = '0;
        for (int i = 0; i < LO_W; i++) begin
            sum_lo = sum_lo + FINE_W'(code_q[i]);
        end
        for (int i = LO_W; i < NTAPS; i++) begin
            sum_hi = sum_hi + FINE_W'(code_q[i]);
        end
    end

    // Tap synchroniser, coarse/flush counters, capture and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            code_q      <= '0;
            count_q     <= '0;
            coarse_cap  <= '0;
            timeout_cap <= 1'b0;
            pop_lo      <= '0;
            pop_hi      <= '0;
            flush_cnt   <= '0;
            coarse_o    <= '0;
            fine_o      <= '0;
            timeout_o   <= 1'b0;
        end else begin
            s1 <= taps_i;
            s2 <= s1;
            case (state)
                IDLE: begin
                    if (arm_i) count_q <= '0;
                end
                ARMED: begin
                    if (hit) begin
                        code_q      <= s2;
                        coarse_cap  <= count_q;
                        timeout_cap <= 1'b0;
                    end else if (count_q == COUNT_LAST) begin
                        code_q      <= '0;
                        coarse_cap  <= count_q;
                        timeout_cap <= 1'b1;
                    end else begin
                        count_q <= count_q + COARSE_W'(1);
                    end
                end
                ENC1: begin
                    pop_lo <= sum_lo;
                    pop_hi <= sum_hi;
                end
                ENC2: begin
                    coarse_o  <= coarse_cap;
                    fine_o    <= pop_lo + pop_hi;
                    timeout_o <= timeout_cap;
                end
                HOLD: begin
                    if (ready_i) flush_cnt <= '0;
                end
                FLUSH: begin
                    if (flush_cnt < FLUSH_MIN) flush_cnt <= flush_cnt + FLUSH_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
